// File: rtl/full_ctrl_pkg.sv
// full_ctrl shared definitions: MAC pipeline depth and
// the controller state encoding used by the MAC-lane controllers.
package full_ctrl_pkg;

  localparam int MAC_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int line_depth(input int rdlat);
    return rdlat + MAC_LAT;
  endfunction

endpackage

// File: rtl/full_ctrl_if.sv
// full_ctrl job/buffer/MAC strobe bundle.
// slave = controller side; master = job issuer / observer side.
interface full_ctrl_if #(
  parameter int AWIDTH = 10
);
  logic              start;
  logic [AWIDTH:0]   len;
  logic              busy;
  logic [AWIDTH-1:0] addr;
  logic              rd_en;
  logic              bias_sel;
  logic              mac_reset;
  logic              mac_accum_we;
  logic              mac_out_en;
  logic              done;

  modport slave (
    input  start, len,
    output busy, addr, rd_en, bias_sel,
    output mac_reset, mac_accum_we,
    output mac_out_en, done
  );

  modport master (
    output start, len,
    input  busy, addr, rd_en, bias_sel,
    input  mac_reset, mac_accum_we,
    input  mac_out_en, done
  );
endinterface

// File: rtl/full_ctrl_delay_line.sv
// delay_line: DEPTH-stage shift line of WIDTH-bit strobes.
// Ports: clk, reset, din -> dout; empty_next = line empty after this edge.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty_next
);

  if (DEPTH == 0) begin : g_wire
    assign dout       = din;
    assign empty_next = 1'b1;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];

    // Contents after the edge are din plus all stages but the tail.
    always_comb begin
      empty_next = (din == '0);
      for (int i = 0; i < DEPTH - 1; i++)
        if (sr[i] != '0) empty_next = 1'b0;
    end
  end

endmodule

// File: rtl/full_ctrl.sv
// full_ctrl: address/strobe sequencer for the `full` MAC lane.
// Ports: clk, xrst (sync, active-high), bus (full_ctrl_if.slave).
// Option: FULL_CTRL_BIAS_EN appends a bias_sel cycle after the last element.
module full_ctrl
  import full_ctrl_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int RDLAT  = 1
) (
  input logic        clk,
  input logic        xrst,
  full_ctrl_if.slave bus
);

`ifdef FULL_CTRL_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam logic [AWIDTH:0] ONE = 1;

  state_t          state, state_n;
  logic [AWIDTH:0] cnt;
  logic [AWIDTH:0] len_q;
  logic            out2;
  logic            last;
  logic            rd_now;
  logic            bias_now;
  logic [1:0]      tail;
  logic            line_empty;

  // With the bias cycle, ISSUE runs one step past N-1.
  assign last = BIAS_EN ? (cnt == len_q)
                        : ((cnt + ONE) == len_q);
  assign rd_now   = (state == ISSUE) && (cnt < len_q);
  assign bias_now = BIAS_EN && (state == ISSUE)
                    && (cnt == len_q);

  delay_line #(
    .WIDTH (2),
    .DEPTH (line_depth(RDLAT))
  ) u_line (
    .clk        (clk),
    .reset      (xrst),
    .din        ({bias_now, rd_now}),
    .dout       (tail),
    .empty_next (line_empty)
  );

  always_ff @(posedge clk) begin
    if (xrst) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      out2  <= 1'b0;
    end else begin
      state <= state_n;
      out2  <= (state == OUT) && !out2;
      if (state == IDLE && bus.start) begin
        len_q <= bus.len;
        cnt   <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + ONE;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.start)
          state_n = (BIAS_EN || bus.len != '0)
                    ? ISSUE : DRAIN;
      ISSUE: if (last) state_n = DRAIN;
      DRAIN: if (line_empty) state_n = OUT;
      OUT:   if (out2) state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.rd_en        = rd_now;
    bus.addr         = rd_now ? cnt[AWIDTH-1:0] : '0;
    bus.bias_sel     = bias_now;
    bus.mac_reset    = (state == IDLE) && bus.start
                       && !xrst;
    bus.mac_accum_we = |tail;
    bus.mac_out_en   = (state == OUT) && !out2;
    bus.done         = (state == OUT) && out2;
  end

endmodule

// File: tb/tb_full_ctrl.sv
// tb_full_ctrl: directed checks of full_ctrl at RDLAT 0/1/4.
// A counting MAC stub (x=w=1.0) yields y = number of accum_we.
module tb_full_ctrl;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        xrst;
  logic        start;
  logic [AW:0] len;
  int          checks = 0;
  int          errors = 0;
  int          acc [3];
  int          y [3];

  always #5 clk = ~clk;

  full_ctrl_if #(.AWIDTH(AW)) b0 ();
  full_ctrl_if #(.AWIDTH(AW)) b1 ();
  full_ctrl_if #(.AWIDTH(AW)) b4 ();

  assign b0.start = start;
  assign b0.len   = len;
  assign b1.start = start;
  assign b1.len   = len;
  assign b4.start = start;
  assign b4.len   = len;

  full_ctrl #(.AWIDTH(AW), .RDLAT(0)) u0 (
    .clk(clk), .xrst(xrst), .bus(b0.slave));
  full_ctrl #(.AWIDTH(AW), .RDLAT(1)) u1 (
    .clk(clk), .xrst(xrst), .bus(b1.slave));
  full_ctrl #(.AWIDTH(AW), .RDLAT(4)) u4 (
    .clk(clk), .xrst(xrst), .bus(b4.slave));

  always @(posedge clk) begin
    if (xrst || b0.mac_reset) acc[0] <= 0;
    else if (b0.mac_accum_we) acc[0] <= acc[0] + 1;
    if (xrst) y[0] <= 0;
    else if (b0.mac_out_en) y[0] <= acc[0];
  end

  always @(posedge clk) begin
    if (xrst || b1.mac_reset) acc[1] <= 0;
    else if (b1.mac_accum_we) acc[1] <= acc[1] + 1;
    if (xrst) y[1] <= 0;
    else if (b1.mac_out_en) y[1] <= acc[1];
  end

  always @(posedge clk) begin
    if (xrst || b4.mac_reset) acc[2] <= 0;
    else if (b4.mac_accum_we) acc[2] <= acc[2] + 1;
    if (xrst) y[2] <= 0;
    else if (b4.mac_out_en) y[2] <= acc[2];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // k = cycle relative to acceptance (k=0); n = job length.
  task automatic chk_inst(input int i, input int r,
                          input int n, input int k);
    logic          rd, rs, we, oe, dn, bz, bs;
    logic [AW-1:0] ad;
    int            yy, oek;
    string         p;
    case (i)
      0: begin
        rd = b0.rd_en; rs = b0.mac_reset;
        we = b0.mac_accum_we; oe = b0.mac_out_en;
        dn = b0.done; bz = b0.busy;
        bs = b0.bias_sel; ad = b0.addr; yy = y[0];
      end
      1: begin
        rd = b1.rd_en; rs = b1.mac_reset;
        we = b1.mac_accum_we; oe = b1.mac_out_en;
        dn = b1.done; bz = b1.busy;
        bs = b1.bias_sel; ad = b1.addr; yy = y[1];
      end
      default: begin
        rd = b4.rd_en; rs = b4.mac_reset;
        we = b4.mac_accum_we; oe = b4.mac_out_en;
        dn = b4.done; bz = b4.busy;
        bs = b4.bias_sel; ad = b4.addr; yy = y[2];
      end
    endcase
    oek = (n > 0) ? n + r + 4 : 2;
    p = $sformatf("rdlat%0d n%0d k%0d ", r, n, k);
    chk({p, "mac_reset"}, 32'(rs), int'(k == 0));
    chk({p, "busy"}, 32'(bz),
        int'(k >= 1 && k <= oek + 1));
    chk({p, "rd_en"}, 32'(rd),
        int'(k >= 1 && k <= n));
    chk({p, "accum_we"}, 32'(we),
        int'(n > 0 && k >= r + 4 && k <= n + r + 3));
    chk({p, "out_en"}, 32'(oe), int'(k == oek));
    chk({p, "done"}, 32'(dn), int'(k == oek + 1));
    chk({p, "bias_sel"}, 32'(bs), 0);
    if (k >= 1 && k <= n)
      chk({p, "addr"}, 32'(ad), k - 1);
    if (k == oek + 1)
      chk({p, "y"}, 32'(yy), n);
  endtask

  task automatic chk_all(input int n, input int k);
    chk_inst(0, 0, n, k);
    chk_inst(1, 1, n, k);
    chk_inst(2, 4, n, k);
  endtask

  // pulse=1 re-asserts start (with another len) while busy.
  task automatic job(input int n, input bit pulse);
    int maxd;
    maxd = (n > 0) ? n + 9 : 3;
    @(posedge clk); #1;
    start = 1'b1;
    len   = (AW + 1)'(n);
    @(negedge clk);
    chk_all(n, 0);
    for (int k = 1; k <= maxd; k++) begin
      @(posedge clk); #1;
      start = pulse && (k <= n + 4);
      len   = pulse ? (AW + 1)'(n + 3) : (AW + 1)'(n);
      @(negedge clk);
      chk_all(n, k);
    end
  endtask

  initial begin
    xrst  = 1'b1;
    start = 1'b0;
    len   = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all(0, -5);
    @(posedge clk); #1;
    xrst = 1'b0;
    @(negedge clk);
    chk_all(0, -5);

    job(4, 1'b0);
    job(0, 1'b0);
    job(8, 1'b1);
    job(3, 1'b0);

    @(posedge clk); #1;
    start = 1'b1;
    len   = (AW + 1)'(6);
    @(negedge clk);
    chk_all(6, 0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk_all(6, k);
    end
    @(posedge clk); #1;
    xrst = 1'b1;
    @(posedge clk); #1;
    xrst = 1'b0;
    @(negedge clk);
    chk_all(0, -5);
    chk("reset y0", 32'(y[0]), 0);

    job(2, 1'b0);
    job(5, 1'b0);
    job(1, 1'b0);
    job(1024, 1'b0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_ctrl.md
Name: full_ctrl

Overview:
- Sequencer directly upstream of the `full` MAC lane in the LSTM datapath.
- On a start pulse it walks the x/w buffer addresses for one dot product of `len` elements.
- It drives the MAC strobes `reset`, `accum_we` and `out_en`, delay-aligned to the buffer read latency plus the MAC's internal 3-register pipeline (operand, product, rounded product).
- It signals `done` in the cycle the MAC output `y` becomes valid.

Parameters:
- AWIDTH, 10, buffer address width; max vector length 2^AWIDTH.
- RDLAT, 1, x/w buffer read latency in cycles (address cycle -> data at MAC inputs); legal 0..4.

Ports:
- clk  input  1  clock.
- xrst  input  1  synchronous reset, active-high: 1 = reset; sampled on posedge clk.
- start  input  1  job request; accepted only in IDLE.
- len  input  AWIDTH+1  element count N, sampled when start is accepted; 0 is legal.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- addr  output  AWIDTH  x/w buffer read address.
- rd_en  output  1  buffer read enable; addr is valid when high.
- bias_sel  output  1  upstream mux select for the bias term (optional feature).
- mac_reset  output  1  to `full.reset`.
- mac_accum_we  output  1  to `full.accum_we`.
- mac_out_en  output  1  to `full.out_en`.
- done  output  1  one-cycle pulse; `full.y` holds the result in this cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, element counter 0, delay-line valid bits cleared.
- Reset mid-job aborts the job immediately and issues no further strobes. The MAC is reset by the same signal.
- Pipeline constant: MAC_LAT = 3. An element whose address is issued in cycle c must have mac_accum_we high in cycle c+RDLAT+MAC_LAT.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - start=1 -> latch len, pulse mac_reset this cycle, clear counter.
  - Next state is ISSUE if len>0, else DRAIN.
  - start in any other state is ignored, with no side effects.
- ISSUE:
  - rd_en=1, addr=counter; counter increments each cycle.
  - After addr=N-1 -> DRAIN.
  - Exactly N consecutive cycles, no bubbles.
- Strobe delay: rd_en (and bias_sel) enter a valid shift line of depth RDLAT+MAC_LAT; its tail drives mac_accum_we.
- DRAIN: wait until the shift line is empty, then -> OUT.
- OUT:
  - Cycle 1: mac_out_en=1.
  - Cycle 2: done=1 (y$ now holds accum$), then -> IDLE.
  - Next start is accepted in the cycle after done.
- len=0: no rd_en and no accum_we. mac_out_en still fires, so y=0 and done pulses.
- Latency: start accepted in cycle s, len=N>0 -> last accum_we at s+N+RDLAT+MAC_LAT, mac_out_en one cycle later, done one cycle after that.
- busy: 0 in the acceptance cycle and in IDLE; 1 from s+1 through the done cycle.
- mac_reset never coincides with mac_accum_we. This is guaranteed because acceptance only happens in IDLE with an empty line.
- Counter width AWIDTH+1 with no wrap. For len=2^AWIDTH, addr spans 0..2^AWIDTH-1.

Optional Feature:
- Macro FULL_CTRL_BIAS_EN.
- Defined:
  - After the last element, ISSUE adds one extra cycle with rd_en=0 and bias_sel=1.
  - Upstream then feeds x = fixed-point 1.0 and w = bias.
  - mac_accum_we fires N+1 times; done moves one cycle later.
  - len=0 yields a bias-only sum.
- Undefined: bias_sel is tied 0; timing is as above.

Decomposition:
- parameters.svh gains MAC_LAT=3 and the state encoding (IDLE/ISSUE/DRAIN/OUT localparams), shared with `full` and other MAC-lane controllers.
- One sub-module, `delay_line` (params WIDTH, DEPTH; DEPTH=0 acts as a wire). It implements the strobe alignment and is reusable for other lanes.

Test Plan:
- len=4, RDLAT=1, start at cycle 10:
  - mac_reset@10.
  - rd_en@11..14 with addr 0,1,2,3.
  - accum_we@15..18.
  - out_en@19, done@20.
  - With x=w=1.0 (DWIDTH fixed point), y=4.0 at cycle 20.
- len=0 -> no rd_en and no accum_we; out_en one cycle after DRAIN; done with y=0; busy high for exactly those cycles.
- start pulsed repeatedly during a len=8 job -> ignored. A back-to-back start at the cycle after done is accepted, and both results are correct.
- xrst asserted in the 3rd ISSUE cycle of a len=6 job -> next cycle all outputs 0, state IDLE. A following len=2 job is correct.
- RDLAT=0 and RDLAT=4 sweeps with len=5 -> accum_we exactly 5 cycles, starting at s+1+RDLAT+3.
- FULL_CTRL_BIAS_EN, len=3, x=w=1.0, bias=0.5 -> bias_sel pulse one cycle after addr=2, 4 accum_we, y=3.5.
